// File: rtl/register.sv
// General-purpose load-enabled storage register with asynchronous active-high reset.
// The output comes straight from the flops; there is no combinational path from in to out.
module register #(
    parameter int unsigned             WIDTH       = 32,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Reset wins over a coincident load; otherwise capture on enable, else hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out <= RESET_VALUE;
        end else if (enable) begin
            out <= in;
        end
    end

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed scenarios plus randomized traffic,
// compared against a behavioural model on a 32-bit and an 8-bit instance.
module tb_register;

    localparam int unsigned W8  = 8;
    localparam logic [7:0]  RV8 = 8'hA5;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic [31:0] dout;
    logic        en8;
    logic [7:0]  din8;
    logic [7:0]  dout8;

    int total;
    int bad;

    logic [31:0] m32;
    logic [7:0]  m8;

    register dut32 (
        .CLK    (clk),
        .RST    (rst),
        .enable (en),
        .in     (din),
        .out    (dout)
    );

    register #(.WIDTH(W8), .RESET_VALUE(RV8)) dut8 (
        .CLK    (clk),
        .RST    (rst),
        .enable (en8),
        .in     (din8),
        .out    (dout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reset forces both model registers to their reset values.
    task automatic model_reset();
        m32 = 32'h0;
        m8  = RV8;
    endtask

    // Advance one rising edge, update the model from the levels present at the edge,
    // then compare both instances one time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (en)  m32 = din;
            if (en8) m8  = din8;
        end
        #1;
        check(tag, dout, m32);
        check({tag, "_w8"}, 32'(dout8), 32'(m8));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        en    = 1'b0;
        din   = 32'h0;
        en8   = 1'b0;
        din8  = 8'h00;
        m32   = 'x;
        m8    = 'x;

        // Asynchronous reset mid-cycle with a pending load.
        @(posedge clk);
        #2;
        en   = 1'b1;
        din  = 32'hFFFF_1111;
        en8  = 1'b1;
        din8 = 8'h3C;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", dout, 32'h0000_0000);
        check("rst_async_w8", 32'(dout8), 32'h0000_00A5);
        for (int i = 0; i < 3; i++) cyc("rst_hold");
        check("rst_held", dout, 32'h0000_0000);
        #3;
        rst = 1'b0;
        cyc("rst_release_load");
        check("first_load", dout, 32'hFFFF_1111);
        check("first_load_w8", 32'(dout8), 32'h0000_003C);

        // Hold with in changing between edges, then a late enable.
        en  = 1'b0;
        en8 = 1'b0;
        #3;
        din  = 32'h0000_0001;
        din8 = 8'h01;
        for (int i = 0; i < 3; i++) cyc("hold");
        check("hold_val", dout, 32'hFFFF_1111);
        #8;
        en = 1'b1;
        cyc("late_enable");
        check("late_enable_val", dout, 32'h0000_0001);

        // Back-to-back loads, then drop enable mid-cycle.
        din = 32'h0001_0001;
        cyc("b2b_0");
        #3;
        din = 32'hF001_0001;
        cyc("b2b_1");
        check("b2b_1_val", dout, 32'hF001_0001);
        #3;
        en  = 1'b0;
        din = 32'h1234_5678;
        cyc("b2b_drop");
        cyc("b2b_drop2");
        check("b2b_drop_val", dout, 32'hF001_0001);

        // Enable glitch wholly between edges must not load.
        #2;
        en  = 1'b1;
        din = 32'hDEAD_BEEF;
        #3;
        en = 1'b0;
        cyc("glitch");
        check("glitch_val", dout, 32'hF001_0001);

        // Reset asserted just ahead of an enabled edge wins; release then load.
        en  = 1'b1;
        din = 32'hAAAA_5555;
        #6;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_during_load_async", dout, 32'h0000_0000);
        cyc("rst_during_load_edge");
        check("rst_during_load_val", dout, 32'h0000_0000);
        #2;
        rst = 1'b0;
        cyc("post_rst_load");
        check("post_rst_load_val", dout, 32'hAAAA_5555);

        // Data extremes.
        din = 32'hFFFF_FFFF; en8 = 1'b1; din8 = 8'hFF;
        cyc("ext_ones");
        din = 32'h0000_0000; din8 = 8'h00;
        cyc("ext_zeros");
        din = 32'h8000_0001; din8 = 8'h81;
        cyc("ext_mixed");
        check("ext_mixed_val", dout, 32'h8000_0001);

        // Randomized traffic with occasional mid-cycle glitches and reset pulses.
        for (int i = 0; i < 300; i++) begin
            #($urandom_range(1, 3));
            en   = 1'($urandom_range(0, 1));
            din  = $urandom;
            en8  = 1'($urandom_range(0, 1));
            din8 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check("rand_rst", dout, m32);
                check("rand_rst_w8", 32'(dout8), 32'(m8));
                #1;
                rst = 1'b0;
            end
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
